// File: rtl/dummy_axi_lite_slave.sv
// Read-only AXI4-Lite slave stub returning {ID_BASE[31:4], addr}.
// One read outstanding; all outputs registered.
module dummy_axi_lite_slave #(
    parameter logic [31:0] ID_BASE = 32'hC0DE_0000
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic [3:0]  axi_araddr,
    input  logic        axi_arvalid,
    input  logic        axi_rready,
    output logic        axi_arready,
    output logic        axi_rvalid,
    output logic [31:0] axi_rdata
);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t      state, state_n;
    logic        arready_n;
    logic        rvalid_n;
    logic [31:0] rdata_n;

    // axi_aresetn is active-high despite its name.
    always_ff @(posedge axi_aclk or posedge axi_aresetn) begin
        if (axi_aresetn) begin
            state       <= IDLE;
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rdata   <= 32'h0;
        end else begin
            state       <= state_n;
            axi_arready <= arready_n;
            axi_rvalid  <= rvalid_n;
            axi_rdata   <= rdata_n;
        end
    end

    always_comb begin
        state_n   = state;
        arready_n = axi_arready;
        rvalid_n  = axi_rvalid;
        rdata_n   = axi_rdata;
        unique case (state)
            IDLE: begin
                // arready is 0 for one cycle after reset, blocking a handshake.
                if (axi_arready && axi_arvalid) begin
                    rdata_n   = {ID_BASE[31:4], axi_araddr};
                    rvalid_n  = 1'b1;
                    arready_n = 1'b0;
                    state_n   = RESP;
                end else begin
                    arready_n = 1'b1;
                end
            end
            RESP: begin
                if (axi_rready) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dummy_axi_lite_slave.sv
// Directed bench for dummy_axi_lite_slave.
// Two instances: default ID_BASE and an overridden one.
module tb_dummy_axi_lite_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  araddr = 4'd0;
    logic        arvalid = 1'b0;
    logic        rready = 1'b0;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;

    logic [3:0]  araddr2 = 4'd0;
    logic        arvalid2 = 1'b0;
    logic        rready2 = 1'b0;
    logic        arready2;
    logic        rvalid2;
    logic [31:0] rdata2;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dummy_axi_lite_slave dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst),
        .axi_araddr  (araddr),
        .axi_arvalid (arvalid),
        .axi_rready  (rready),
        .axi_arready (arready),
        .axi_rvalid  (rvalid),
        .axi_rdata   (rdata)
    );

    dummy_axi_lite_slave #(.ID_BASE(32'h1234_5678)) dut2 (
        .axi_aclk    (clk),
        .axi_aresetn (rst),
        .axi_araddr  (araddr2),
        .axi_arvalid (arvalid2),
        .axi_rready  (rready2),
        .axi_arready (arready2),
        .axi_rvalid  (rvalid2),
        .axi_rdata   (rdata2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic ar, input logic rv,
                          input logic [31:0] rd);
        chk({tag, ".arready"}, {31'd0, arready}, {31'd0, ar});
        chk({tag, ".rvalid"}, {31'd0, rvalid}, {31'd0, rv});
        chk({tag, ".rdata"}, rdata, rd);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_st("reset", 1'b0, 1'b0, 32'h0);

        // Release with arvalid already high on address 0
        rst = 1'b0;
        arvalid = 1'b1;
        araddr = 4'd0;
        tick();
        chk_st("post_rst_e1", 1'b1, 1'b0, 32'h0);
        tick();
        chk_st("hs_addr0", 1'b0, 1'b1, 32'hC0DE_0000);

        // arvalid with addr 1 while in RESP is ignored
        araddr = 4'd1;
        tick();
        chk_st("ignore_ar_1", 1'b0, 1'b1, 32'hC0DE_0000);
        tick();
        chk_st("ignore_ar_2", 1'b0, 1'b1, 32'hC0DE_0000);
        arvalid = 1'b0;
        rready = 1'b1;
        tick();
        chk_st("r_hs_0", 1'b1, 1'b0, 32'hC0DE_0000);
        rready = 1'b0;

        // Address 15
        arvalid = 1'b1;
        araddr = 4'd15;
        tick();
        chk_st("hs_addr15", 1'b0, 1'b1, 32'hC0DE_000F);
        arvalid = 1'b0;
        tick();
        chk_st("hold_addr15", 1'b0, 1'b1, 32'hC0DE_000F);
        rready = 1'b1;
        tick();
        chk_st("r_hs_15", 1'b1, 1'b0, 32'hC0DE_000F);
        rready = 1'b0;

        // Back-to-back reads of 3 then 4
        arvalid = 1'b1;
        rready = 1'b1;
        araddr = 4'd3;
        tick();
        chk_st("b2b_3", 1'b0, 1'b1, 32'hC0DE_0003);
        araddr = 4'd4;
        tick();
        chk_st("b2b_r_only", 1'b1, 1'b0, 32'hC0DE_0003);
        tick();
        chk_st("b2b_4", 1'b0, 1'b1, 32'hC0DE_0004);
        arvalid = 1'b0;
        tick();
        chk_st("b2b_done", 1'b1, 1'b0, 32'hC0DE_0004);
        rready = 1'b0;

        // Reset asserted mid-RESP, no clock edge in between
        arvalid = 1'b1;
        araddr = 4'd7;
        tick();
        chk_st("hs_addr7", 1'b0, 1'b1, 32'hC0DE_0007);
        arvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_st("async_rst", 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        arvalid = 1'b1;
        araddr = 4'd9;
        tick();
        chk_st("rerst_e1", 1'b1, 1'b0, 32'h0);
        tick();
        chk_st("hs_addr9", 1'b0, 1'b1, 32'hC0DE_0009);
        arvalid = 1'b0;

        // Overridden ID_BASE instance, address 2
        chk("id2_idle_arready", {31'd0, arready2}, 32'd1);
        arvalid2 = 1'b1;
        araddr2 = 4'd2;
        tick();
        chk("id2_rvalid", {31'd0, rvalid2}, 32'd1);
        chk("id2_rdata", rdata2, 32'h1234_5672);
        arvalid2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
